// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
//   CH_NUM     : number of output channels
//   SEL_W      : width of the per-beat channel select
//   DEF_DATA_W : default payload width
//   DEF_CNT_W  : default per-channel beat counter width
//   ch_lsb()   : lsb position of channel k inside a flattened k*w bus
package demux_pkg;

  localparam int CH_NUM     = 4;
  localparam int SEL_W      = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry register slice for a single demux output channel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   fill       : load in_data into the slot on this edge
//   in_data    : payload to load
//   out_ready  : downstream consumer accepts the held beat
//   out_valid  : slot holds a beat (FULL)
//   out_data   : held payload; keeps its last value after draining
module stream_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              drain;

  assign drain = vld_p1 && out_ready;

  // Stage p1: slot register. Fill wins over drain, so a drain+fill in the
  // same cycle keeps the slot FULL with the new beat and no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (fill) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: rtl/stream_demux_1x4.sv
// Registered 1-to-4 stream demultiplexer with valid/ready on every port.
// Each accepted beat is routed to the one-entry slot of the channel named by
// in_sel, and a saturating accepted-beat count is kept per channel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : upstream beat present
//   in_ready   : beat accepted this cycle (combinational from in_sel/out_ready)
//   in_sel     : destination channel 0..3
//   in_data    : payload
//   out_valid  : bit k set when channel k slot is FULL
//   out_ready  : bit k set when channel k consumer accepts
//   out_data   : channel k payload in bits [k*DATA_W +: DATA_W]
//   cnt_clr    : synchronous clear of all counters (beats up to 1 per edge)
//   cnt        : channel k count in bits [k*CNT_W +: CNT_W]
module stream_demux_1x4
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [CH_NUM-1:0]        out_valid,
  input  logic [CH_NUM-1:0]        out_ready,
  output logic [CH_NUM*DATA_W-1:0] out_data,
  input  logic                     cnt_clr,
  output logic [CH_NUM*CNT_W-1:0]  cnt
);

  logic [CH_NUM-1:0] fill;
  logic [CNT_W-1:0]  cnt_p1 [CH_NUM];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Only the selected channel gates acceptance, so a stalled channel never
  // blocks beats headed elsewhere. Independent of in_valid by design.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign fill[k] = in_valid && in_ready && (in_sel == SEL_W'(k));

    stream_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .fill     (fill[k]),
      .in_data  (in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (out_data[ch_lsb(k, DATA_W) +: DATA_W])
    );

    // Stage p1: per-channel counter; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_p1[k] <= '0;
      end else if (cnt_clr) begin
        cnt_p1[k] <= '0;
      end else if (fill[k]) begin
        cnt_p1[k] <= sat_inc(cnt_p1[k]);
      end
    end

    assign cnt[ch_lsb(k, CNT_W) +: CNT_W] = cnt_p1[k];
  end

endmodule

// File: tb/tb_stream_demux_1x4.sv
module tb_stream_demux_1x4;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sel = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'b0000;
  logic [4*DW-1:0] out_data;
  logic          cnt_clr = 1'b0;
  logic [4*CW-1:0] cnt;

  stream_demux_1x4 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cnt_clr  (cnt_clr),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-channel scoreboard queues, slot state, counters.
  logic [DW-1:0] q [4][$];
  logic [3:0]    mvalid = 4'b0000;
  int            mcnt [4] = '{0, 0, 0, 0};
  bit            acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mvalid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      mcnt[k] = 0;
      q[k].delete();
    end
  endtask

  // One clock: check everything at the negedge, advance the model, return
  // 1 time unit after the rising edge so the caller can drive new inputs.
  task automatic step();
    logic exp_rdy;
    logic fill_k;
    exp_rdy = 1'b0;
    fill_k  = 1'b0;
    @(negedge clk);
    exp_rdy = !mvalid[in_sel] || out_ready[in_sel];
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(mvalid));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cnt%0d", k), 64'(cnt[k*CW +: CW]), 64'(mcnt[k]));
    end
    acc = in_valid && exp_rdy;
    for (int k = 0; k < 4; k++) begin
      fill_k = acc && (in_sel == 2'(k));
      if (mvalid[k]) begin
        if (q[k].size() == 0) chk($sformatf("sb_empty%0d", k), 64'd1, 64'd0);
        else chk($sformatf("out_data%0d", k), 64'(out_data[k*DW +: DW]), 64'(q[k][0]));
        if (out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
      end
      if (fill_k) begin
        q[k].push_back(in_data);
        mvalid[k] = 1'b1;
      end else if (mvalid[k] && out_ready[k]) begin
        mvalid[k] = 1'b0;
      end
      if (cnt_clr) mcnt[k] = 0;
      else if (fill_k && mcnt[k] < CMAX) mcnt[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    do begin
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Power-on reset
    #1;
    reset_checks("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sweep: one beat per channel, all consumers ready
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) send(2'(k), 8'hA0 + 8'(k));
    for (int k = 0; k < 4; k++) chk($sformatf("sweep_cnt%0d", k), 64'(cnt[k*CW +: CW]), 64'd1);
    step();

    // Backpressure on channel 2 only
    out_ready = 4'b1011;
    send(2'd2, 8'h11);
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 8'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall", 64'(acc), 64'd0);
    end
    out_ready = 4'b1111;
    step();
    chk("bp_release", 64'(acc), 64'd1);
    in_valid = 1'b0;
    step();
    step();

    // Streaming into channel 3 after clearing the counters
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 16; i++) send(2'd3, 8'(8'h40 + i));
    chk("stream_cnt3", 64'(cnt[3*CW +: CW]), 64'd16);
    chk("stream_vld3", 64'(out_valid[3]), 64'd1);
    step();

    // Saturation then clear colliding with a beat
    for (int i = 0; i < 260; i++) send(2'd0, 8'(i));
    chk("sat_cnt0", 64'(cnt[0 +: CW]), 64'(CMAX));
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'h5A;
    cnt_clr  = 1'b1;
    step();
    chk("clr_acc", 64'(acc), 64'd1);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    chk("clr_cnt0", 64'(cnt[0 +: CW]), 64'd0);
    step();

    // Reset mid-stream with every slot full and a stalled beat pending
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) send(2'(k), 8'hC0 + 8'(k));
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 8'hD1;
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks("mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    step();
    chk("post_rst_acc", 64'(acc), 64'd1);
    in_valid = 1'b0;
    send(2'd2, 8'hE2);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
